// File: rtl/crtc_init_sequencer.sv
// crtc_init_sequencer: writes a 40/80-column timing preset into the CRTC over the CPU-shared port.
// Define CRTC_SEQ_RESTORE_AR_EN to rewrite the CPU's last address-register value after the sequence.
module crtc_init_sequencer (
    input  logic       sys_clock_i,
    input  logic       reset_i,
    input  logic       wr_strobe_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       cpu_cs_i,
    input  logic       cpu_rw_ni,
    input  logic       cpu_rs_i,
    input  logic [7:0] cpu_data_i,
    output logic       crtc_wr_strobe_o,
    output logic       crtc_cs_o,
    output logic       crtc_rw_no,
    output logic       crtc_rs_o,
    output logic [7:0] crtc_data_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESTORE, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       mode_q, mode_d;
    logic       slot, land, cpu_aw;
    logic [3:0] reg_num;
    logic [7:0] preset, seq_data, ar_data;
    assign slot   = state_q == ADDR || state_q == DATA || state_q == RESTORE;
    assign land   = slot && wr_strobe_i && !cpu_cs_i;
    assign cpu_aw = wr_strobe_i && cpu_cs_i && !cpu_rs_i && !cpu_rw_ni;
`ifdef CRTC_SEQ_RESTORE_AR_EN
    localparam state_t LAST = RESTORE;
    logic [4:0] ar_q, ar_d;
    always_comb ar_d = cpu_aw ? cpu_data_i[4:0] : ar_q;
    always_ff @(posedge sys_clock_i or posedge reset_i)
        if (reset_i) ar_q <= 5'd0;
        else         ar_q <= ar_d;
    assign ar_data = {3'd0, ar_q};
`else
    localparam state_t LAST = DONE;
    assign ar_data = 8'd0;
`endif
    // Entry list R0..R7, R9, R12, R13 and both presets
    always_comb begin
        reg_num = idx_q;
        case (idx_q)
            4'd0:    preset = mode_q ? 8'd49  : 8'd63;
            4'd1:    preset = 8'd40;
            4'd2:    preset = mode_q ? 8'd41  : 8'd48;
            4'd3:    preset = mode_q ? 8'h0F  : 8'h01;
            4'd4:    preset = 8'd32;
            4'd5:    preset = mode_q ? 8'd3   : 8'd5;
            4'd6:    preset = 8'd25;
            4'd7:    preset = mode_q ? 8'd29  : 8'd28;
            4'd8:    begin reg_num = 4'd9;  preset = mode_q ? 8'd9 : 8'd7; end
            4'd9:    begin reg_num = 4'd12; preset = 8'h10; end
            default: begin reg_num = 4'd13; preset = 8'h00; end
        endcase
    end
    always_ff @(posedge sys_clock_i or posedge reset_i)
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE:    if (start_i) begin
                         state_d = ADDR;
                         idx_d   = 4'd0;
                         mode_d  = mode_i;
                     end
            ADDR:    if (land) state_d = DATA;
            DATA:    if (land) begin
                         state_d = idx_q == 4'd10 ? LAST : ADDR;
                         idx_d   = idx_q + 4'd1;
                     end else if (cpu_aw) state_d = ADDR; // CPU moved the AR: reissue our address
            RESTORE: if (land) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        seq_data         = state_q == ADDR ? {4'd0, reg_num} : state_q == DATA ? preset : ar_data;
        busy_o           = slot;
        done_o           = state_q == DONE;
        crtc_wr_strobe_o = wr_strobe_i && (cpu_cs_i || slot);
        crtc_cs_o        = cpu_cs_i || land;
        crtc_rw_no       = cpu_cs_i ? cpu_rw_ni : !land;
        crtc_rs_o        = land ? state_q == DATA : cpu_rs_i;
        crtc_data_o      = land ? seq_data : cpu_data_i;
    end
endmodule

// File: tb/tb_crtc_init_sequencer.sv
// tb_crtc_init_sequencer: CRTC register model plus a queue of expected sequencer writes.
module tb_crtc_init_sequencer;
    logic sys_clock_i = 0, reset_i = 1, wr_strobe_i = 0, start_i = 0, mode_i = 0;
    logic cpu_cs_i = 0, cpu_rw_ni = 1, cpu_rs_i = 1;
    logic [7:0] cpu_data_i = 8'h5A;
    logic crtc_wr_strobe_o, crtc_cs_o, crtc_rw_no, crtc_rs_o, busy_o, done_o;
    logic [7:0] crtc_data_o;
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, seq_cnt = 0;
    logic [7:0] crtc_reg [32] = '{default: 8'h00};
    logic [4:0] crtc_ar = 5'd0;
    logic [4:0] shadow_exp = 5'd0;
    logic [8:0] exp_q [$];
    int reg_list [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 12, 13};
    logic [7:0] pre [2][11] = '{'{8'd63, 8'd40, 8'd48, 8'h01, 8'd32, 8'd5, 8'd25, 8'd28, 8'd7, 8'h10, 8'h00},
                                '{8'd49, 8'd40, 8'd41, 8'h0F, 8'd32, 8'd3, 8'd25, 8'd29, 8'd9, 8'h10, 8'h00}};
    typedef struct {
        logic wr, cs, rw, rs;
        logic [7:0] d;
        logic e_wr, e_cs, e_rw, e_rs;
        logic [7:0] e_d;
    } vec_t;
    vec_t vecs [6];

    crtc_init_sequencer dut (
        .sys_clock_i(sys_clock_i), .reset_i(reset_i), .wr_strobe_i(wr_strobe_i),
        .start_i(start_i), .mode_i(mode_i), .cpu_cs_i(cpu_cs_i), .cpu_rw_ni(cpu_rw_ni),
        .cpu_rs_i(cpu_rs_i), .cpu_data_i(cpu_data_i), .crtc_wr_strobe_o(crtc_wr_strobe_o),
        .crtc_cs_o(crtc_cs_o), .crtc_rw_no(crtc_rw_no), .crtc_rs_o(crtc_rs_o),
        .crtc_data_o(crtc_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 sys_clock_i = ~sys_clock_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model of the CRTC write port; pops the scoreboard on every sequencer-owned write
    always @(negedge sys_clock_i) if (!reset_i) begin
        if (crtc_wr_strobe_o && crtc_cs_o && !crtc_rw_no) begin
            if (crtc_rs_o) crtc_reg[crtc_ar] = crtc_data_o;
            else crtc_ar = crtc_data_o[4:0];
            if (!cpu_cs_i) begin
                seq_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL seq_unexpected actual=%0h required=none", {crtc_rs_o, crtc_data_o});
                end else chk("seq_write", {crtc_rs_o, crtc_data_o}, exp_q.pop_front());
            end
        end
        if (done_o) begin
            done_cnt++;
            chk("busy_at_done", busy_o, 0);
        end
    end

    task automatic step();
        @(posedge sys_clock_i);
        #1;
        cyc++;
        wr_strobe_i = (cyc % 4 == 0);
    endtask

    task automatic push_seq(input logic m, input int dup);
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({1'b0, 8'(reg_list[i])});
            if (i == dup) exp_q.push_back({1'b0, 8'(reg_list[i])});
            exp_q.push_back({1'b1, pre[m][i]});
        end
`ifdef CRTC_SEQ_RESTORE_AR_EN
        exp_q.push_back({1'b0, 3'b0, shadow_exp});
`endif
    endtask

    task automatic start_seq(input logic m, input int dup);
        do step(); while (!wr_strobe_i);
        chk("busy_before_start", busy_o, 0);
        start_i = 1;
        mode_i = m;
        push_seq(m, dup);
        #1 chk("start_slot_no_write", {crtc_cs_o, crtc_wr_strobe_o}, 0);
        step();
        start_i = 0;
        chk("busy_rise", busy_o, 1);
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (seq_cnt < n && k < 600) begin step(); k++; end
        chk("reach_write", seq_cnt >= n, 1);
    endtask

    task automatic wait_done(input string tag);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 600) begin step(); n++; end
        repeat (6) step();
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_busy_low"}, busy_o, 0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_regs(input logic m, input string tag);
        for (int i = 0; i < 11; i++) chk($sformatf("%s_R%0d", tag, reg_list[i]), crtc_reg[reg_list[i]], pre[m][i]);
`ifdef CRTC_SEQ_RESTORE_AR_EN
        chk({tag, "_final_ar"}, crtc_ar, shadow_exp);
`else
        chk({tag, "_final_ar"}, crtc_ar, 13);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, frozen, d0;
        vecs[0] = '{0, 0, 0, 0, 8'hAA, 0, 0, 1, 0, 8'hAA};
        vecs[1] = '{1, 0, 0, 1, 8'h55, 0, 0, 1, 1, 8'h55};
        vecs[2] = '{1, 1, 0, 0, 8'h03, 1, 1, 0, 0, 8'h03};
        vecs[3] = '{0, 1, 1, 1, 8'hC3, 0, 1, 1, 1, 8'hC3};
        vecs[4] = '{1, 1, 1, 0, 8'h7E, 1, 1, 1, 0, 8'h7E};
        vecs[5] = '{1, 0, 1, 1, 8'h01, 0, 0, 1, 1, 8'h01};
        #2;
        chk("rst_outputs", {busy_o, done_o, crtc_cs_o, crtc_rw_no, crtc_wr_strobe_o}, 5'b00010);
        chk("rst_mux_idle", {crtc_rs_o, crtc_data_o}, {1'b1, 8'h5A});
        @(posedge sys_clock_i);
        #1 reset_i = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clock_i);
            #1;
            wr_strobe_i = vecs[i].wr;
            cpu_cs_i = vecs[i].cs;
            cpu_rw_ni = vecs[i].rw;
            cpu_rs_i = vecs[i].rs;
            cpu_data_i = vecs[i].d;
            #1 chk($sformatf("idle_vec%0d", i),
                   {crtc_wr_strobe_o, crtc_cs_o, crtc_rw_no, crtc_rs_o, crtc_data_o},
                   {vecs[i].e_wr, vecs[i].e_cs, vecs[i].e_rw, vecs[i].e_rs, vecs[i].e_d});
        end
        @(posedge sys_clock_i);
        #1;
        wr_strobe_i = 0;
        cpu_cs_i = 0;
        cpu_rw_ni = 1;
        reset_i = 1;
        #1 chk("async_rst_idle", {busy_o, crtc_cs_o, crtc_rw_no}, 3'b001);
        @(posedge sys_clock_i);
        #1 reset_i = 0;
        shadow_exp = 0;

        start_seq(0, -1);
        wait_done("m0");
        check_regs(0, "m0");

        start_seq(1, -1);
        wait_done("m1");
        check_regs(1, "m1");

        base = seq_cnt;
        start_seq(0, 4);
        wait_writes(base + 9);
        do step(); while (!wr_strobe_i);
        cpu_cs_i = 1;
        cpu_rw_ni = 0;
        cpu_rs_i = 0;
        cpu_data_i = 8'd6;
        shadow_exp = 5'd6;
        #1 chk("clobber_passthru", {crtc_wr_strobe_o, crtc_cs_o, crtc_rw_no, crtc_rs_o, crtc_data_o},
               {4'b1100, 8'd6});
        step();
        cpu_cs_i = 0;
        cpu_rw_ni = 1;
        wait_done("clobber");
        check_regs(0, "clobber");

        base = seq_cnt;
        start_seq(1, -1);
        wait_writes(base + 7);
        do step(); while (!wr_strobe_i);
        cpu_cs_i = 1;
        cpu_rw_ni = 1;
        frozen = seq_cnt;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) do step(); while (!wr_strobe_i);
            cpu_rs_i = 1'($urandom);
            cpu_data_i = 8'($urandom);
            #1 chk($sformatf("hold_mirror%0d", s),
                   {crtc_wr_strobe_o, crtc_cs_o, crtc_rw_no, crtc_rs_o, crtc_data_o},
                   {3'b111, cpu_rs_i, cpu_data_i});
            chk("hold_busy", busy_o, 1);
        end
        step();
        cpu_cs_i = 0;
        chk("hold_frozen", seq_cnt, frozen);
        wait_done("hold");
        check_regs(1, "hold");

        start_seq(0, -1);
        repeat (3) step();
        start_i = 1;
        mode_i = 1;
        step();
        start_i = 0;
        wait_done("restart_ignored");
        check_regs(0, "restart_ignored");

        base = seq_cnt;
        start_seq(1, -1);
        wait_writes(base + 6);
        d0 = done_cnt;
        reset_i = 1;
        #1 chk("midrun_rst_outputs", {busy_o, done_o, crtc_cs_o, crtc_rw_no, crtc_wr_strobe_o}, 5'b00010);
        exp_q.delete();
        shadow_exp = 0;
        repeat (4) step();
        chk("midrun_rst_no_done", done_cnt, d0);
        chk("midrun_R2_kept", crtc_reg[2], 8'd41);
        chk("midrun_R3_untouched", crtc_reg[3], 8'h01);
        reset_i = 0;
        start_seq(0, -1);
        wait_done("after_rst");
        check_regs(0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
